// File: rtl/nts_api_arbiter.sv
// Two-requester round-robin arbiter in front of a single-outstanding downstream API port.
// Each transaction is issued once and then completed by a read-data valid or by a timeout abort.
module nts_api_arbiter #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd16
) (
    input  logic        i_clk,
    input  logic        i_areset,

    input  logic        i_req0_cs,
    input  logic        i_req0_we,
    input  logic [11:0] i_req0_address,
    input  logic [31:0] i_req0_write_data,
    output logic        o_req0_ack,
    output logic        o_req0_error,

    input  logic        i_req1_cs,
    input  logic        i_req1_we,
    input  logic [11:0] i_req1_address,
    input  logic [31:0] i_req1_write_data,
    output logic        o_req1_ack,
    output logic        o_req1_error,

    output logic [31:0] o_read_data,

    output logic        o_api_cs,
    output logic        o_api_we,
    output logic [11:0] o_api_address,
    output logic [31:0] o_api_write_data,
    input  logic [31:0] i_api_read_data,
    input  logic        i_api_read_data_valid,
    input  logic        i_api_busy,

    output logic [15:0] o_timeout_count
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t     state;
    logic       grant;
    logic       prio;
    logic [7:0] wait_cnt;
    logic [7:0] wait_next;

    logic       pick_valid;
    logic       pick;

    // On a tie the requester named by prio wins; prio always points away from the last one served.
    always_comb begin
        pick_valid = i_req0_cs | i_req1_cs;
        pick       = 1'b0;
        if (i_req0_cs && i_req1_cs) begin
            pick = prio;
        end else begin
            pick = i_req1_cs;
        end
        wait_next = wait_cnt + 8'd1;
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state            <= IDLE;
            grant            <= 1'b0;
            prio             <= 1'b0;
            wait_cnt         <= 8'd0;
            o_req0_ack       <= 1'b0;
            o_req1_ack       <= 1'b0;
            o_req0_error     <= 1'b0;
            o_req1_error     <= 1'b0;
            o_read_data      <= 32'd0;
            o_api_cs         <= 1'b0;
            o_api_we         <= 1'b0;
            o_api_address    <= 12'd0;
            o_api_write_data <= 32'd0;
            o_timeout_count  <= 16'd0;
        end else begin
            o_req0_ack <= 1'b0;
            o_req1_ack <= 1'b0;
            o_api_cs   <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick_valid && !i_api_busy) begin
                        grant            <= pick;
                        prio             <= ~pick;
                        o_api_we         <= pick ? i_req1_we : i_req0_we;
                        o_api_address    <= pick ? i_req1_address : i_req0_address;
                        o_api_write_data <= pick ? i_req1_write_data : i_req0_write_data;
                        o_api_cs         <= 1'b1;
                        state            <= ISSUE;
                    end
                end

                ISSUE: begin
                    wait_cnt <= 8'd0;
                    state    <= WAIT;
                end

                // Valid is tested first so a response in the final allowed cycle still completes cleanly.
                WAIT: begin
                    if (i_api_read_data_valid) begin
                        o_read_data  <= i_api_read_data;
                        o_req0_error <= 1'b0;
                        o_req1_error <= 1'b0;
                        o_req0_ack   <= ~grant;
                        o_req1_ack   <= grant;
                        state        <= DONE;
                    end else if (wait_next == TIMEOUT_CYCLES) begin
                        o_read_data  <= 32'd0;
                        o_req0_error <= ~grant;
                        o_req1_error <= grant;
                        o_req0_ack   <= ~grant;
                        o_req1_ack   <= grant;
                        if (o_timeout_count != 16'hFFFF) begin
                            o_timeout_count <= o_timeout_count + 16'd1;
                        end
                        state        <= DONE;
                    end else begin
                        wait_cnt <= wait_next;
                    end
                end

                DONE: begin
                    o_req0_error <= 1'b0;
                    o_req1_error <= 1'b0;
                    state        <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nts_api_arbiter.sv
// Directed bench for nts_api_arbiter: a small downstream responder plus per-transaction timing checks.
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_nts_api_arbiter;

    logic        i_clk;
    logic        i_areset;
    logic        i_req0_cs, i_req0_we, i_req1_cs, i_req1_we;
    logic [11:0] i_req0_address, i_req1_address;
    logic [31:0] i_req0_write_data, i_req1_write_data;
    logic        o_req0_ack, o_req0_error, o_req1_ack, o_req1_error;
    logic [31:0] o_read_data;
    logic        o_api_cs, o_api_we;
    logic [11:0] o_api_address;
    logic [31:0] o_api_write_data;
    logic [31:0] i_api_read_data;
    logic        i_api_read_data_valid;
    logic        i_api_busy;
    logic [15:0] o_timeout_count;

    int total = 0;
    int bad   = 0;

    logic        resp_en;
    int          resp_delay;
    int          resp_cnt;
    logic        resp_valid;
    logic        stray_valid;
    logic [31:0] resp_data;

    int          cs_cycle, cs_count, ack_cycle, ack_who, ack_width;
    logic [11:0] cs_addr;
    logic        cs_we;
    logic [31:0] cs_wdata, ack_rdata;
    logic        ack_err;
    int          cnt;

    assign i_api_read_data_valid = resp_valid | stray_valid;
    assign i_api_read_data       = resp_data;

    nts_api_arbiter #(.TIMEOUT_CYCLES(8'd16)) dut (
        .i_clk                 (i_clk),
        .i_areset              (i_areset),
        .i_req0_cs             (i_req0_cs),
        .i_req0_we             (i_req0_we),
        .i_req0_address        (i_req0_address),
        .i_req0_write_data     (i_req0_write_data),
        .o_req0_ack            (o_req0_ack),
        .o_req0_error          (o_req0_error),
        .i_req1_cs             (i_req1_cs),
        .i_req1_we             (i_req1_we),
        .i_req1_address        (i_req1_address),
        .i_req1_write_data     (i_req1_write_data),
        .o_req1_ack            (o_req1_ack),
        .o_req1_error          (o_req1_error),
        .o_read_data           (o_read_data),
        .o_api_cs              (o_api_cs),
        .o_api_we              (o_api_we),
        .o_api_address         (o_api_address),
        .o_api_write_data      (o_api_write_data),
        .i_api_read_data       (i_api_read_data),
        .i_api_read_data_valid (i_api_read_data_valid),
        .i_api_busy            (i_api_busy),
        .o_timeout_count       (o_timeout_count)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Downstream model: valid pulses resp_delay cycles after the cycle in which cs is seen.
    always @(negedge i_clk) begin
        if (resp_cnt > 0) begin
            resp_cnt   = resp_cnt - 1;
            resp_valid = (resp_cnt == 0);
        end else begin
            resp_valid = 1'b0;
        end
        if (o_api_cs && resp_en) resp_cnt = resp_delay;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int who, input logic cs, input logic we,
                                 input logic [11:0] addr, input logic [31:0] wdata);
        if (who == 0) begin
            i_req0_cs = cs; i_req0_we = we; i_req0_address = addr; i_req0_write_data = wdata;
        end else begin
            i_req1_cs = cs; i_req1_we = we; i_req1_address = addr; i_req1_write_data = wdata;
        end
    endtask

    // Called at the falling edge of the cycle in which the request is first sampled (cycle 0).
    task automatic runTxn(input int max_cycles, input bit drop_on_ack, input int drop_cycle);
        cs_cycle = -1; cs_count = 0; ack_cycle = -1; ack_who = -1; ack_width = 0;
        cs_addr = '0; cs_we = 1'b0; cs_wdata = '0; ack_rdata = '0; ack_err = 1'b0;
        for (int i = 1; i <= max_cycles; i++) begin
            @(negedge i_clk);
            if (i == drop_cycle) begin
                i_req0_cs = 1'b0;
                i_req1_cs = 1'b0;
            end
            if (o_api_cs) begin
                cs_count++;
                if (cs_cycle < 0) begin
                    cs_cycle = i; cs_addr = o_api_address; cs_we = o_api_we; cs_wdata = o_api_write_data;
                end
            end
            if (o_req0_ack || o_req1_ack) begin
                ack_cycle = i;
                ack_who   = o_req1_ack ? 1 : 0;
                ack_err   = o_req1_ack ? o_req1_error : o_req0_error;
                ack_rdata = o_read_data;
                if (o_req0_ack && o_req1_ack) ack_who = 2;
                if (drop_on_ack) applyStimulus(ack_who, 1'b0, 1'b0, 12'h000, 32'h0);
                @(negedge i_clk);
                ack_width = (o_req0_ack || o_req1_ack) ? 2 : 1;
                break;
            end
        end
    endtask

    initial begin
        i_areset = 1'b1; i_api_busy = 1'b0; stray_valid = 1'b0; resp_valid = 1'b0;
        resp_en = 1'b0; resp_delay = 3; resp_cnt = 0; resp_data = 32'h0;
        applyStimulus(0, 1'b0, 1'b0, 12'h000, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 12'h000, 32'h0);
        repeat (3) @(negedge i_clk);

        checkOutput("rst_ack0", {31'd0, o_req0_ack}, 32'd0);
        checkOutput("rst_ack1", {31'd0, o_req1_ack}, 32'd0);
        checkOutput("rst_err",  {30'd0, o_req0_error, o_req1_error}, 32'd0);
        checkOutput("rst_cs",   {31'd0, o_api_cs}, 32'd0);
        checkOutput("rst_rdata", o_read_data, 32'd0);
        checkOutput("rst_addr", {20'd0, o_api_address}, 32'd0);
        checkOutput("rst_we_wd", o_api_write_data | {31'd0, o_api_we}, 32'd0);
        checkOutput("rst_tocnt", {16'd0, o_timeout_count}, 32'd0);
        i_areset = 1'b0;

        // Single read with a 3-cycle downstream.
        @(negedge i_clk);
        resp_en = 1'b1; resp_delay = 3; resp_data = 32'hCAFEBABE;
        applyStimulus(0, 1'b1, 1'b0, 12'h010, 32'h0);
        runTxn(30, 1'b1, 0);
        checkOutput("rd_cs_cycle", cs_cycle, 1);
        checkOutput("rd_cs_count", cs_count, 1);
        checkOutput("rd_cs_addr", {20'd0, cs_addr}, 32'h010);
        checkOutput("rd_cs_we", {31'd0, cs_we}, 32'd0);
        checkOutput("rd_ack_cycle", ack_cycle, 5);
        checkOutput("rd_ack_who", ack_who, 0);
        checkOutput("rd_ack_width", ack_width, 1);
        checkOutput("rd_rdata", ack_rdata, 32'hCAFEBABE);
        checkOutput("rd_err", {31'd0, ack_err}, 32'd0);

        // Timeout: no response ever, 16 WAIT cycles (2..17) then ack at 18.
        resp_en = 1'b0;
        applyStimulus(1, 1'b1, 1'b0, 12'h0AA, 32'h0);
        runTxn(40, 1'b1, 0);
        checkOutput("to_ack_cycle", ack_cycle, 18);
        checkOutput("to_ack_who", ack_who, 1);
        checkOutput("to_err", {31'd0, ack_err}, 32'd1);
        checkOutput("to_rdata", ack_rdata, 32'd0);
        checkOutput("to_count", {16'd0, o_timeout_count}, 32'd1);

        // Write from requester 1.
        resp_en = 1'b1; resp_delay = 3; resp_data = 32'h0;
        applyStimulus(1, 1'b1, 1'b1, 12'h3FF, 32'h12345678);
        runTxn(30, 1'b1, 0);
        checkOutput("wr_cs_we", {31'd0, cs_we}, 32'd1);
        checkOutput("wr_cs_addr", {20'd0, cs_addr}, 32'h3FF);
        checkOutput("wr_cs_wdata", cs_wdata, 32'h12345678);
        checkOutput("wr_ack_who", ack_who, 1);
        checkOutput("wr_ack_cycle", ack_cycle, 5);
        checkOutput("wr_rdata", ack_rdata, 32'd0);

        // Valid arrives in the last WAIT cycle: must complete without error.
        resp_delay = 16; resp_data = 32'hA5A50001;
        applyStimulus(0, 1'b1, 1'b0, 12'h011, 32'h0);
        runTxn(40, 1'b1, 0);
        checkOutput("co_ack_cycle", ack_cycle, 18);
        checkOutput("co_err", {31'd0, ack_err}, 32'd0);
        checkOutput("co_rdata", ack_rdata, 32'hA5A50001);
        checkOutput("co_count", {16'd0, o_timeout_count}, 32'd1);

        // Busy hold: no issue while busy, issue the cycle after it drops.
        resp_delay = 3; resp_data = 32'h600DF00D;
        i_api_busy = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 12'h020, 32'h0);
        cnt = 0;
        repeat (6) begin
            @(negedge i_clk);
            if (o_api_cs) cnt++;
        end
        checkOutput("busy_no_cs", cnt, 0);
        i_api_busy = 1'b0;
        runTxn(30, 1'b1, 0);
        checkOutput("busy_cs_cycle", cs_cycle, 1);
        checkOutput("busy_ack_cycle", ack_cycle, 5);
        checkOutput("busy_rdata", ack_rdata, 32'h600DF00D);

        // Stray valid while idle must not produce an ack.
        stray_valid = 1'b1; cnt = 0;
        repeat (6) begin
            @(negedge i_clk);
            stray_valid = 1'b0;
            if (o_req0_ack || o_req1_ack) cnt++;
        end
        checkOutput("stray_acks", cnt, 0);

        // Requester drops cs after grant; the transaction still completes.
        resp_data = 32'h0000BEEF;
        applyStimulus(0, 1'b1, 1'b0, 12'h030, 32'h0);
        runTxn(30, 1'b1, 2);
        checkOutput("drop_ack_who", ack_who, 0);
        checkOutput("drop_ack_cycle", ack_cycle, 5);

        // Reset while in WAIT abandons the transaction.
        resp_en = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 12'h055, 32'h0);
        repeat (3) @(negedge i_clk);
        i_areset = 1'b1;
        #1;
        checkOutput("wrst_acks", {30'd0, o_req0_ack, o_req1_ack}, 32'd0);
        checkOutput("wrst_cs", {31'd0, o_api_cs}, 32'd0);
        checkOutput("wrst_rdata", o_read_data, 32'd0);
        checkOutput("wrst_addr", {20'd0, o_api_address}, 32'd0);
        checkOutput("wrst_tocnt", {16'd0, o_timeout_count}, 32'd0);
        applyStimulus(0, 1'b0, 1'b0, 12'h000, 32'h0);
        @(negedge i_clk);
        i_areset = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge i_clk);
            if (o_req0_ack || o_req1_ack || o_api_cs) cnt++;
        end
        checkOutput("wrst_quiet", cnt, 0);
        resp_en = 1'b1; resp_delay = 3; resp_data = 32'h00000066;
        applyStimulus(1, 1'b1, 1'b0, 12'h066, 32'h0);
        runTxn(30, 1'b1, 0);
        checkOutput("wrst_req1_who", ack_who, 1);
        checkOutput("wrst_req1_cycle", ack_cycle, 5);

        // Contention from reset: both held, grants alternate starting with requester 0.
        i_areset = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 12'h100, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 12'h200, 32'h0);
        @(negedge i_clk);
        i_areset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            runTxn(30, 1'b0, 0);
            checkOutput($sformatf("rr%0d_who", k), ack_who, k % 2);
            checkOutput($sformatf("rr%0d_addr", k), {20'd0, cs_addr}, (k % 2) ? 32'h200 : 32'h100);
            checkOutput($sformatf("rr%0d_cs_count", k), cs_count, 1);
            checkOutput($sformatf("rr%0d_ack_cycle", k), ack_cycle, 5);
            checkOutput($sformatf("rr%0d_width", k), ack_width, 1);
        end
        applyStimulus(0, 1'b0, 1'b0, 12'h000, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 12'h000, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
